// File: rtl/port_io.sv
// port_io: buffered core<->device I/O port with a TX FIFO drained over valid/ready
// and a first-word-fall-through RX FIFO, plus sticky overflow/underflow flags.
`default_nettype none

module port_io #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             wr_en_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [WIDTH-1:0] tx_data_o,
    output logic             tx_valid_o,
    input  logic             tx_ready_i,
    input  logic [WIDTH-1:0] rx_data_i,
    input  logic             rx_valid_i,
    output logic             rx_ready_o,
    output logic             tx_full_o,
    output logic             rx_empty_o,
    output logic             ovf_o,
    output logic             udf_o,
    input  logic             clr_err_i
);

    localparam int             PW      = $clog2(DEPTH);
    localparam logic [PW-1:0]  PTR_INC = PW'(1);
    localparam logic [PW:0]    CNT_INC = (PW+1)'(1);
    localparam logic [PW:0]    CNT_MAX = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] tx_mem_q [DEPTH];
    logic [WIDTH-1:0] rx_mem_q [DEPTH];

    logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [PW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [PW:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;

    logic tx_push, tx_pop, rx_push, rx_pop;
    logic tx_full, tx_valid, rx_ready, rx_empty;

    assign tx_full  = (tx_cnt_q == CNT_MAX);
    assign tx_valid = (tx_cnt_q != '0);
    assign rx_ready = (rx_cnt_q != CNT_MAX);
    assign rx_empty = (rx_cnt_q == '0);

    // A full TX FIFO still accepts a write when the head leaves in the same cycle.
    assign tx_pop  = tx_valid & tx_ready_i;
    assign tx_push = wr_en_i & (~tx_full | tx_pop);
    assign rx_push = rx_valid_i & rx_ready;
    assign rx_pop  = rd_en_i & ~rx_empty;

    always_comb begin
        tx_wp_d  = tx_wp_q;
        tx_rp_d  = tx_rp_q;
        tx_cnt_d = tx_cnt_q;
        rx_wp_d  = rx_wp_q;
        rx_rp_d  = rx_rp_q;
        rx_cnt_d = rx_cnt_q;
        if (tx_push) tx_wp_d = tx_wp_q + PTR_INC;
        if (tx_pop)  tx_rp_d = tx_rp_q + PTR_INC;
        if (rx_push) rx_wp_d = rx_wp_q + PTR_INC;
        if (rx_pop)  rx_rp_d = rx_rp_q + PTR_INC;
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + CNT_INC;
            2'b01:   tx_cnt_d = tx_cnt_q - CNT_INC;
            default: tx_cnt_d = tx_cnt_q;
        endcase
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + CNT_INC;
            2'b01:   rx_cnt_d = rx_cnt_q - CNT_INC;
            default: rx_cnt_d = rx_cnt_q;
        endcase
        // Error set takes priority over a coincident clear.
        ovf_d = (wr_en_i & ~tx_push) | (ovf_q & ~clr_err_i);
        udf_d = (rd_en_i & rx_empty) | (udf_q & ~clr_err_i);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            tx_cnt_q <= tx_cnt_d;
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            rx_cnt_q <= rx_cnt_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is not reset; the counts alone decide what is visible.
    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem_q[tx_wp_q] <= din_i;
        if (rx_push) rx_mem_q[rx_wp_q] <= rx_data_i;
    end

    assign tx_data_o  = tx_valid ? tx_mem_q[tx_rp_q] : '0;
    assign dout_o     = rx_empty ? '0 : rx_mem_q[rx_rp_q];
    assign tx_valid_o = tx_valid;
    assign tx_full_o  = tx_full;
    assign rx_ready_o = rx_ready;
    assign rx_empty_o = rx_empty;
    assign ovf_o      = ovf_q;
    assign udf_o      = udf_q;

endmodule

`default_nettype wire

// File: tb/tb_port_io.sv
// tb_port_io: scoreboard bench for port_io; a negedge monitor models both FIFOs
// and the sticky flags, directed sequences add explicit checks.
`default_nettype none

module tb_port_io;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic [WIDTH-1:0] din, rx_data;
    logic             wr_en, rd_en, tx_ready, rx_valid, clr_err;
    logic [WIDTH-1:0] dout, tx_data;
    logic             tx_valid, rx_ready, tx_full, rx_empty, ovf, udf;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] tx_q[$];
    logic [WIDTH-1:0] rx_q[$];
    logic             ovf_m = 1'b0;
    logic             udf_m = 1'b0;

    port_io #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .din_i      (din),
        .wr_en_i    (wr_en),
        .rd_en_i    (rd_en),
        .dout_o     (dout),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready),
        .tx_full_o  (tx_full),
        .rx_empty_o (rx_empty),
        .ovf_o      (ovf),
        .udf_o      (udf),
        .clr_err_i  (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Model compares against the state left by the previous edge, then advances.
    always @(negedge clk) begin
        logic tp, tpu, rp, rpu;
        if (!rstn) begin
            tx_q.delete();
            rx_q.delete();
            ovf_m = 1'b0;
            udf_m = 1'b0;
        end
        check("m_tx_valid", tx_valid, tx_q.size() != 0);
        check("m_tx_full",  tx_full,  tx_q.size() == DEPTH);
        check("m_tx_data",  tx_data,  tx_q.size() != 0 ? tx_q[0] : '0);
        check("m_rx_empty", rx_empty, rx_q.size() == 0);
        check("m_rx_ready", rx_ready, rx_q.size() != DEPTH);
        check("m_dout",     dout,     rx_q.size() != 0 ? rx_q[0] : '0);
        check("m_ovf",      ovf,      ovf_m);
        check("m_udf",      udf,      udf_m);
        if (rstn) begin
            tp  = tx_ready && tx_q.size() != 0;
            tpu = wr_en && (tx_q.size() < DEPTH || tp);
            rp  = rd_en && rx_q.size() != 0;
            rpu = rx_valid && rx_q.size() < DEPTH;
            ovf_m = (wr_en && !tpu) || (ovf_m && !clr_err);
            udf_m = (rd_en && rx_q.size() == 0) || (udf_m && !clr_err);
            if (tp)  void'(tx_q.pop_front());
            if (tpu) tx_q.push_back(din);
            if (rp)  void'(rx_q.pop_front());
            if (rpu) rx_q.push_back(rx_data);
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] fill [4];
        logic [WIDTH-1:0] rxw  [5];
        fill = '{8'hDE, 8'hAB, 8'hDC, 8'h11};
        rxw  = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};

        rstn = 1'b0; wr_en = 1'b1; rx_valid = 1'b1; din = 8'h77; rx_data = 8'h99;
        rd_en = 1'b0; tx_ready = 1'b0; clr_err = 1'b0;
        cyc(); cyc();
        check("rst_tx_valid", tx_valid, 0);
        check("rst_rx_ready", rx_ready, 1);
        check("rst_rx_empty", rx_empty, 1);
        check("rst_dout", dout, 0);
        check("rst_ovf_udf", {ovf, udf}, 0);
        rstn = 1'b1;
        cyc();
        check("first_push_valid", tx_valid, 1);
        check("first_push_data", tx_data, 8'h77);
        check("first_rx_dout", dout, 8'h99);
        wr_en = 1'b0; rx_valid = 1'b0; tx_ready = 1'b1; rd_en = 1'b1;
        cyc();
        tx_ready = 1'b0; rd_en = 1'b0;

        // TX fill, overflow, drain
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; din = fill[i];
            cyc();
        end
        check("tx_full_after_fill", tx_full, 1);
        din = 8'h22;
        cyc();
        check("tx_ovf_set", ovf, 1);
        wr_en = 1'b0; tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("tx_drain_data", tx_data, fill[i]);
            cyc();
        end
        check("tx_drained_valid", tx_valid, 0);
        tx_ready = 1'b0; clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        check("ovf_cleared", ovf, 0);

        // TX full with simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; din = 8'(i + 1);
            cyc();
        end
        din = 8'h55; tx_ready = 1'b1;
        cyc();
        check("tx_simul_full", tx_full, 1);
        check("tx_simul_ovf", ovf, 0);
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("tx_simul_drain", tx_data, (i == 3) ? 8'h55 : 8'(i + 2));
            cyc();
        end
        tx_ready = 1'b0;

        // RX path, underflow
        rx_valid = 1'b1; rx_data = 8'hAC;
        cyc();
        rx_data = 8'h5A;
        cyc();
        rx_valid = 1'b0; rd_en = 1'b1;
        check("rx_dout_first", dout, 8'hAC);
        cyc();
        check("rx_dout_second", dout, 8'h5A);
        cyc();
        check("rx_empty_after_pops", rx_empty, 1);
        check("rx_dout_empty", dout, 0);
        cyc();
        check("rx_udf_set", udf, 1);
        rd_en = 1'b0; clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        check("udf_cleared", udf, 0);

        // RX full: fifth word held by the device until a pop frees a slot
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1; rx_data = rxw[i];
            cyc();
        end
        check("rx_full_ready", rx_ready, 0);
        rx_data = rxw[4];
        cyc();
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        check("rx_ready_after_pop", rx_ready, 1);
        cyc();
        rx_valid = 1'b0; rd_en = 1'b1;
        for (int i = 1; i < 5; i++) begin
            check("rx_wrap_order", dout, rxw[i]);
            cyc();
        end
        rd_en = 1'b0;

        // Clear coinciding with overflow: set wins
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; din = 8'(8'hA0 + i);
            cyc();
        end
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0; wr_en = 1'b0;
        check("ovf_set_wins", ovf, 1);

        // Async reset mid-transfer with words in both FIFOs
        rx_valid = 1'b1; rx_data = 8'hC1;
        cyc();
        rx_data = 8'hC2;
        cyc();
        rx_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("arst_tx_valid", tx_valid, 0);
        check("arst_tx_full", tx_full, 0);
        check("arst_tx_data", tx_data, 0);
        check("arst_rx_ready", rx_ready, 1);
        check("arst_rx_empty", rx_empty, 1);
        check("arst_dout", dout, 0);
        check("arst_ovf_udf", {ovf, udf}, 0);
        cyc();
        rstn = 1'b1; wr_en = 1'b1; din = 8'h3C;
        cyc();
        wr_en = 1'b0;
        check("post_arst_push", tx_data, 8'h3C);
        tx_ready = 1'b1;
        cyc();
        tx_ready = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
